// File: rtl/multi_light_controller_pkg.sv
// Shared definitions for the multi-light controller: scheduler state encodings,
// LFSR feedback taps and the default power-up seed.
package multi_light_controller_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_BTWN = 2'd1,
        ST_PICK      = 2'd2
    } sched_state_e;

    // Taps 16,14,13,11 of a 16-bit Fibonacci LFSR map to bits 15,13,12,10.
    localparam logic [15:0] LFSR_TAPS    = 16'hB400;
    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

    function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
        return {cur[14:0], ^(cur & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Fibonacci LFSR used as the light-selection random source.
// A loaded zero seed is replaced by 1 so the register can never lock up.
module lfsr16
    import multi_light_controller_pkg::*;
#(
    parameter logic [15:0] SEED = DEFAULT_SEED
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [15:0] seed,
    output logic [15:0] num
);

    logic [15:0] num_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            num_q <= SEED;
        end else if (load) begin
            num_q <= (seed == 16'h0000) ? 16'h0001 : seed;
        end else begin
            num_q <= lfsr_next(num_q);
        end
    end

    assign num = num_q;

endmodule

// File: rtl/multi_light_controller.sv
// Whack-a-mole style light scheduler: lights random lamps at a fixed gap, each held
// by a slot timer until it is hit or expires; hits and misses are counted per cycle.
module multi_light_controller
    import multi_light_controller_pkg::*;
#(
    parameter int          NUM_LIGHTS = 9,
    parameter int          NUM_SLOTS  = 2,
    parameter int          TIMER_W    = 28,
    parameter logic [15:0] SEED       = DEFAULT_SEED
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               start,
    input  logic                               load_seed,
    input  logic [15:0]                        seed_in,
    input  logic [TIMER_W-1:0]                 time_on,
    input  logic [TIMER_W-1:0]                 time_between,
    input  logic [NUM_LIGHTS-1:0]              hit,
    output logic [NUM_LIGHTS-1:0]              lights,
    output logic [3:0]                         light_pos,
    output logic [$clog2(NUM_SLOTS+1)-1:0]     hit_cnt,
    output logic [$clog2(NUM_SLOTS+1)-1:0]     miss_cnt
);

    localparam int CNT_W = $clog2(NUM_SLOTS + 1);

    sched_state_e            state_q;
    logic [TIMER_W-1:0]      gap_q;
    logic [3:0]              light_pos_q;
    logic [NUM_LIGHTS-1:0]   lights_q, lights_d;
    logic [CNT_W-1:0]        hit_cnt_q, hit_cnt_d;
    logic [CNT_W-1:0]        miss_cnt_q, miss_cnt_d;

    logic [15:0]             rng;
    logic [15:0]             lights_pad;
    logic [15:0]             hit_pad;
    logic [3:0]              cand;
    logic                    pick_ok;
    logic [NUM_SLOTS-1:0]    slot_busy;
    logic [NUM_SLOTS-1:0]    slot_hit;
    logic [NUM_SLOTS-1:0]    slot_exp;
    logic [NUM_SLOTS-1:0]    claim;
    logic [NUM_LIGHTS-1:0]   slot_clr [NUM_SLOTS];
    logic [NUM_LIGHTS-1:0]   set_mask, clr_mask;

    lfsr16 #(.SEED(SEED)) u_lfsr (
        .clk   (clk),
        .reset (reset),
        .load  (load_seed),
        .seed  (seed_in),
        .num   (rng)
    );

    assign lights_pad = 16'(lights_q);
    assign hit_pad    = 16'(hit);
    assign cand       = 4'(rng % 16'(NUM_LIGHTS));

    // Busy flags are registered, so a slot freed this cycle is only seen free next cycle.
    assign pick_ok  = start && (state_q == ST_PICK) && !(&slot_busy) && !lights_pad[cand];
    // Isolates the lowest clear bit of slot_busy: the lowest-index free slot.
    assign claim    = pick_ok ? (~slot_busy & (slot_busy + NUM_SLOTS'(1))) : '0;
    assign set_mask = pick_ok ? (NUM_LIGHTS'(1) << cand) : '0;

    for (genvar s = 0; s < NUM_SLOTS; s++) begin : g_slot
        logic               busy_q;
        logic [TIMER_W-1:0] tmr_q;
        logic [3:0]         light_q;
        logic               hit_now;
        logic               exp_now;

        // A hit in the expiry cycle takes precedence so the light is never counted twice.
        assign hit_now      = busy_q && hit_pad[light_q];
        assign exp_now      = busy_q && start && (tmr_q == '0) && !hit_now;
        assign slot_busy[s] = busy_q;
        assign slot_hit[s]  = hit_now;
        assign slot_exp[s]  = exp_now;
        assign slot_clr[s]  = (hit_now || exp_now) ? (NUM_LIGHTS'(1) << light_q) : '0;

        always_ff @(posedge clk) begin
            if (!reset) begin
                busy_q  <= 1'b0;
                tmr_q   <= '0;
                light_q <= '0;
            end else if (claim[s]) begin
                busy_q  <= 1'b1;
                tmr_q   <= time_on;
                light_q <= cand;
            end else if (hit_now || exp_now) begin
                busy_q  <= 1'b0;
            end else if (busy_q && start) begin
                tmr_q   <= tmr_q - TIMER_W'(1);
            end
        end
    end

    always_comb begin
        clr_mask   = '0;
        hit_cnt_d  = '0;
        miss_cnt_d = '0;
        for (int s = 0; s < NUM_SLOTS; s++) begin
            clr_mask   = clr_mask | slot_clr[s];
            hit_cnt_d  = hit_cnt_d + CNT_W'(slot_hit[s]);
            miss_cnt_d = miss_cnt_d + CNT_W'(slot_exp[s]);
        end
        lights_d = (lights_q & ~clr_mask) | set_mask;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            gap_q       <= '0;
            light_pos_q <= '0;
        end else if (start) begin
            case (state_q)
                ST_IDLE: begin
                    state_q <= ST_WAIT_BTWN;
                    gap_q   <= time_between;
                end
                ST_WAIT_BTWN: begin
                    if (gap_q == '0) state_q <= ST_PICK;
                    else             gap_q   <= gap_q - TIMER_W'(1);
                end
                ST_PICK: begin
                    if (pick_ok) begin
                        light_pos_q <= cand;
                        gap_q       <= time_between;
                        state_q     <= ST_WAIT_BTWN;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            lights_q   <= '0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            lights_q   <= lights_d;
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign lights    = lights_q;
    assign light_pos = light_pos_q;
    assign hit_cnt   = hit_cnt_q;
    assign miss_cnt  = miss_cnt_q;

endmodule

// File: tb/tb_multi_light_controller.sv
// Bench for multi_light_controller: a per-light behavioural model predicts every cycle's
// outputs into a scoreboard queue, plus directed checks on latency, hits, slots and freeze.
module tb_multi_light_controller;

    localparam int          NL   = 9;
    localparam int          NS   = 2;
    localparam int          TW   = 28;
    localparam int          CW   = 2;
    localparam logic [15:0] SEED = 16'hACE1;

    logic          clk;
    logic          reset;
    logic          start;
    logic          load_seed;
    logic [15:0]   seed_in;
    logic [TW-1:0] time_on;
    logic [TW-1:0] time_between;
    logic [NL-1:0] hit;
    logic [NL-1:0] lights;
    logic [3:0]    light_pos;
    logic [CW-1:0] hit_cnt;
    logic [CW-1:0] miss_cnt;

    multi_light_controller #(
        .NUM_LIGHTS (NL),
        .NUM_SLOTS  (NS),
        .TIMER_W    (TW),
        .SEED       (SEED)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .load_seed    (load_seed),
        .seed_in      (seed_in),
        .time_on      (time_on),
        .time_between (time_between),
        .hit          (hit),
        .lights       (lights),
        .light_pos    (light_pos),
        .hit_cnt      (hit_cnt),
        .miss_cnt     (miss_cnt)
    );

    // clock / watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    int n_checks = 0;
    int n_pass   = 0;

    logic [NL+4+2*CW-1:0] exp_q[$];

    // model state: one entry per light instead of per slot
    int            m_state;
    int            m_gap;
    logic [15:0]   m_lfsr;
    logic [NL-1:0] m_lit;
    int            m_ttl[NL];
    logic [3:0]    m_pos;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic model_step();
        logic [NL-1:0] hits;
        logic [NL-1:0] expd;
        logic [NL-1:0] nlit;
        int hc;
        int mc;
        int cand;
        if (!reset) begin
            m_state = 0;
            m_gap   = 0;
            m_lfsr  = SEED;
            m_lit   = '0;
            m_pos   = '0;
            for (int i = 0; i < NL; i++) m_ttl[i] = 0;
            hc = 0;
            mc = 0;
        end else begin
            hits = hit & m_lit;
            expd = '0;
            for (int i = 0; i < NL; i++)
                if (start && m_lit[i] && !hits[i] && m_ttl[i] == 0) expd[i] = 1'b1;
            nlit = m_lit & ~hits & ~expd;
            for (int i = 0; i < NL; i++)
                if (start && nlit[i]) m_ttl[i] = m_ttl[i] - 1;
            hc = $countones(hits);
            mc = $countones(expd);
            if (start) begin
                case (m_state)
                    0: begin
                        m_state = 1;
                        m_gap   = int'(time_between);
                    end
                    1: begin
                        if (m_gap == 0) m_state = 2;
                        else            m_gap   = m_gap - 1;
                    end
                    default: begin
                        cand = int'(m_lfsr % 16'(NL));
                        if ($countones(m_lit) < NS && !m_lit[cand]) begin
                            nlit[cand]  = 1'b1;
                            m_ttl[cand] = int'(time_on);
                            m_pos       = 4'(cand);
                            m_gap       = int'(time_between);
                            m_state     = 1;
                        end
                    end
                endcase
            end
            m_lit = nlit;
            if (load_seed) m_lfsr = (seed_in == 16'h0) ? 16'h0001 : seed_in;
            else m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
        end
        exp_q.push_back({m_lit, m_pos, CW'(hc), CW'(mc)});
    endtask

    // driver: predict, clock once, then compare just after the edge
    task automatic tick();
        logic [NL+4+2*CW-1:0] exp_v;
        model_step();
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check("sb_underflow", 32'd1, 32'd0);
        end else begin
            exp_v = exp_q.pop_front();
            check("cycle", 32'({lights, light_pos, hit_cnt, miss_cnt}), 32'(exp_v));
        end
    endtask

    task automatic do_reset();
        reset     = 1'b0;
        start     = 1'b0;
        load_seed = 1'b0;
        hit       = '0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    int            p;
    bit            found;
    logic [NL-1:0] prev;
    logic [NL-1:0] snap;
    logic [15:0]   seeds[3];

    initial begin
        reset = 1'b0; start = 1'b0; load_seed = 1'b0; seed_in = '0;
        time_on = '0; time_between = '0; hit = '0;
        p = 0; found = 1'b0;
        seeds[0] = 16'h0000; seeds[1] = 16'h1234; seeds[2] = 16'h1234;

        // reset state
        tick();
        tick();
        check("rst_lights", 32'(lights), 32'd0);
        check("rst_pos", 32'(light_pos), 32'd0);
        check("rst_hit_cnt", 32'(hit_cnt), 32'd0);
        check("rst_miss_cnt", 32'(miss_cnt), 32'd0);

        // first-light latency and lit duration: gap 3, on 4
        time_between = 3; time_on = 4;
        reset = 1'b1; start = 1'b1;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (k == 4) check("first_light_early", 32'($countones(lights)), 32'd0);
            if (k == 5) begin
                check("first_light_edge", 32'($countones(lights)), 32'd1);
                p = int'(m_pos);
            end
            if (k == 9) check("lit_last_cycle", 32'(lights[p]), 32'd1);
            if (k == 10) begin
                check("expired", 32'(lights[p]), 32'd0);
                check("miss_once", 32'(miss_cnt), 32'd1);
            end
            if (k == 11) check("miss_one_cycle", 32'(miss_cnt), 32'd0);
        end

        // hit two cycles after light-up
        do_reset();
        time_between = 3; time_on = 20; start = 1'b1; found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            prev = m_lit;
            tick();
            for (int i = 0; i < NL; i++)
                if (m_lit[i] && !prev[i]) begin found = 1'b1; p = i; end
        end
        if (!found) check("hit_wait_timeout", 32'd0, 32'd1);
        else begin
            tick();
            hit[p] = 1'b1;
            tick();
            hit = '0;
            check("hit_clears", 32'(lights[p]), 32'd0);
            check("hit_cnt", 32'(hit_cnt), 32'd1);
            check("hit_no_miss", 32'(miss_cnt), 32'd0);
        end
        hit = ~m_lit;
        tick();
        hit = '0;
        check("unlit_hit_ignored", 32'(hit_cnt), 32'd0);

        // slot limit: both slots fill, a hit admits a third light
        do_reset();
        time_between = 0; time_on = 1000; start = 1'b1;
        repeat (40) tick();
        check("two_slots", 32'($countones(lights)), 32'd2);
        for (int i = NL - 1; i >= 0; i--) if (m_lit[i]) p = i;
        hit[p] = 1'b1;
        tick();
        hit = '0;
        check("slot_freed", 32'($countones(lights)), 32'd1);
        repeat (20) tick();
        check("third_admitted", 32'($countones(lights)), 32'd2);

        // hit in the same cycle the timer reaches zero
        do_reset();
        time_between = 0; time_on = 3; start = 1'b1; found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            for (int i = 0; i < NL; i++)
                if (m_lit[i] && m_ttl[i] == 0) begin found = 1'b1; p = i; end
            if (found) hit[p] = 1'b1;
            tick();
            hit = '0;
        end
        if (!found) check("hx_wait_timeout", 32'd0, 32'd1);
        else begin
            check("hx_hit_cnt", 32'(hit_cnt), 32'd1);
            check("hx_miss_cnt", 32'(miss_cnt), 32'd0);
            check("hx_cleared", 32'(lights[p]), 32'd0);
        end

        // freeze mid-gap for 10 cycles, then resume
        do_reset();
        time_between = 8; time_on = 200; start = 1'b1; found = 1'b0;
        for (int k = 0; k < 60 && !found; k++) begin
            tick();
            if (m_lit != '0 && m_state == 1 && m_gap == 5) found = 1'b1;
        end
        if (!found) check("freeze_wait_timeout", 32'd0, 32'd1);
        else begin
            snap  = m_lit;
            start = 1'b0;
            repeat (10) tick();
            check("freeze_lights", 32'(lights), 32'(snap));
            start = 1'b1;
            repeat (12) tick();
        end

        // seed loading: zero seed, then the same seed twice
        for (int r = 0; r < 3; r++) begin
            do_reset();
            load_seed = 1'b1; seed_in = seeds[r];
            tick();
            load_seed = 1'b0;
            time_between = 1; time_on = 3; start = 1'b1;
            repeat (40) tick();
        end

        // random traffic with a reset in the middle
        do_reset();
        time_between = 2; time_on = 4;
        for (int k = 0; k < 400; k++) begin
            start = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 15) == 0) begin
                time_between = TW'($urandom_range(0, 4));
                time_on      = TW'($urandom_range(0, 6));
            end
            hit = '0;
            if ($urandom_range(0, 3) == 0) hit = NL'($urandom());
            load_seed = ($urandom_range(0, 31) == 0);
            seed_in   = ($urandom_range(0, 1) == 0) ? 16'h0000 : 16'($urandom());
            if (k == 200) begin
                reset = 1'b0; load_seed = 1'b1; hit = '1;
            end
            tick();
            if (k == 200) begin
                check("midrst_lights", 32'(lights), 32'd0);
                check("midrst_miss", 32'(miss_cnt), 32'd0);
                check("midrst_hit", 32'(hit_cnt), 32'd0);
                reset = 1'b1;
            end
        end
        hit = '0; start = 1'b0; load_seed = 1'b0;

        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/multi_light_controller.md
MULTI_LIGHT_CONTROLLER -- requirements
Module: multi_light_controller

Interface
REQ-001 Parameter NUM_LIGHTS, default 9, number of board lights (2..16).
REQ-002 Parameter NUM_SLOTS, default 2, maximum simultaneously lit lights (1..NUM_LIGHTS-1).
REQ-003 Parameter TIMER_W, default 28, width of all time counters.
REQ-004 Parameter SEED, default 16'hACE1, LFSR value after reset.
REQ-005 Port list, in order: clk in 1, single clock; reset in 1, synchronous, active-low.
REQ-006 Control inputs: start in 1, run enable; load_seed in 1, load seed_in into RNG; seed_in in 16, RNG seed.
REQ-007 Timing inputs: time_on in TIMER_W, lit duration in cycles; time_between in TIMER_W, gap between light-ups.
REQ-008 hit in NUM_LIGHTS, per-light button strobe, one cycle per press.
REQ-009 Light outputs: lights out NUM_LIGHTS, lamp drive; light_pos out 4, index of most recently lit light.
REQ-010 Score outputs, each out clog2(NUM_SLOTS+1): hit_cnt, lights cleared by hit this cycle; miss_cnt, lights expired this cycle.

Function
REQ-011 Scheduler FSM states: IDLE, WAIT_BTWN, PICK; all transitions occur only while start=1, except reset.
REQ-012 IDLE with start=1 -> WAIT_BTWN; gap counter loads time_between.
REQ-013 WAIT_BTWN: counter==0 -> PICK, else decrement by 1 per cycle.
REQ-014 PICK needs a free slot and candidate = rng mod NUM_LIGHTS with lights[candidate]=0.
REQ-015 PICK outcome: if both hold, set lights[candidate], claim lowest-index free slot, load its timer with time_on, set light_pos, go WAIT_BTWN reloading time_between; otherwise stay in PICK.
REQ-016 Latency: first light rises on clock edge time_between+2 after the edge that samples start=1 in IDLE.
REQ-017 Each busy slot timer: ==0 -> clear its light, free the slot, count one miss; else decrement by 1 per cycle.
REQ-018 An unhit light stays lit exactly time_on+1 cycles.
REQ-019 hit[i]=1 with lights[i]=1 clears the light and frees its slot next edge, counted in hit_cnt; hit on an unlit light is ignored.
REQ-020 Hit and expiry of the same light in one cycle: hit wins, miss not counted.
REQ-021 Multiple hits/expiries in one cycle are all processed; hit_cnt/miss_cnt are registered, valid one cycle, else 0.
REQ-022 A slot freed in cycle n is claimable by PICK in cycle n+1, not n.
REQ-023 start=0: all counters and FSM state freeze, lights hold, RNG keeps advancing; hits still processed.
REQ-024 RNG: 16-bit Fibonacci LFSR, taps 16,14,13,11, advances every cycle; load_seed loads seed_in, zero replaced by 16'h0001.
REQ-025 time_between=0 and time_on=0 are legal (PICK next cycle; light lit one cycle).

Reset
REQ-026 reset=0 at a clock edge: state IDLE, lights=0, light_pos=0, hit_cnt=miss_cnt=0, all slots free, all counters 0, LFSR=SEED.
REQ-027 Reset mid-operation discards lit lights without counting misses; reset dominates load_seed and hit.

Structure
REQ-028 The shared header holds FSM state encodings, LFSR tap constants and the default SEED.
REQ-029 The LFSR is a separate sub-module, lfsr16, with ports clk, reset, load, seed, num.
REQ-030 Slot timers are a generate-loop array inside multi_light_controller, not separate modules.

Verification
REQ-031 Reset, start=1, time_between=3, time_on=4 -> first light edge 5, lit 5 cycles, then miss_cnt=1 for one cycle.
REQ-032 Light i lit, hit[i] pulsed 2 cycles later -> lights[i]=0 next edge, hit_cnt=1, no miss.
REQ-033 NUM_SLOTS=2, time_between=0, long time_on -> exactly 2 lights lit, FSM held in PICK; a hit admits a third one cycle after the slot frees.
REQ-034 hit[i] in the same cycle light i's timer hits 0 -> hit_cnt=1, miss_cnt=0.
REQ-035 start dropped for 10 cycles mid-WAIT_BTWN -> counter and lights frozen; timing resumes exactly where it stopped.
REQ-036 load_seed with seed_in=0 -> LFSR=16'h0001; identical seeds give identical light sequences.
